// File: rtl/muldiv_sequencer_if.sv
// Handshake, result and shared-ALU signals between the core and the MULTU/DIVU sequencer.
// master = core/ALU side, slave = sequencer side.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             alu_sel;
    logic [WIDTH-1:0] alu_srca;
    logic [WIDTH-1:0] alu_srcb;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_result;

    modport master (
        output start, op, a, b, alu_result,
        input  busy, done, hi, lo, alu_sel, alu_srca, alu_srcb, alu_op
    );

    modport slave (
        input  start, op, a, b, alu_result,
        output busy, done, hi, lo, alu_sel, alu_srca, alu_srcb, alu_op
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// MULTU/DIVU sequencer: one shift-add or restoring-divide step per cycle on the shared ALU,
// 64-bit result committed to HI/LO on the edge entering DONE.
module muldiv_sequencer #(
    parameter int         WIDTH   = 32,
    parameter logic [3:0] ALU_ADD = 4'b0010,
    parameter logic [3:0] ALU_SUB = 4'b0110
) (
    input  logic                 clk,
    input  logic                 rst,
    muldiv_sequencer_if.slave    bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [CW-1:0]    count_reg;
    logic             op_reg;
    logic [WIDTH-1:0] acc_reg;      // P_hi for MULTU, partial remainder R for DIVU
    logic [WIDTH-1:0] quo_reg;      // P_lo for MULTU, quotient/dividend Q for DIVU
    logic [WIDTH-1:0] operand_reg;  // M for MULTU, D for DIVU

    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] srca_next;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH:0]   rs;
    logic             ge;

    // One iteration, using the ALU result for the operands currently on srca/srcb.
    always_comb begin
        sum   = quo_reg[0] ? bus.alu_result : acc_reg;
        carry = quo_reg[0] && (bus.alu_result < acc_reg);
        rs    = {acc_reg, quo_reg[WIDTH-1]};
        ge    = (rs >= {1'b0, operand_reg});
        if (op_reg) begin
            acc_next  = ge ? bus.alu_result : rs[WIDTH-1:0];
            quo_next  = {quo_reg[WIDTH-2:0], ge};
            srca_next = {acc_next[WIDTH-2:0], quo_next[WIDTH-1]};
        end else begin
            acc_next  = {carry, sum[WIDTH-1:1]};
            quo_next  = {sum[0], quo_reg[WIDTH-1:1]};
            srca_next = acc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            op_reg       <= 1'b0;
            acc_reg      <= '0;
            quo_reg      <= '0;
            operand_reg  <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.hi       <= '0;
            bus.lo       <= '0;
            bus.alu_sel  <= 1'b0;
            bus.alu_srca <= '0;
            bus.alu_srcb <= '0;
            bus.alu_op   <= ALU_ADD;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        op_reg   <= bus.op;
                        bus.busy <= 1'b1;
                        if (bus.op && (bus.b == '0)) begin
                            bus.hi    <= bus.a;
                            bus.lo    <= '1;
                            bus.done  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            count_reg    <= CW'(WIDTH - 1);
                            acc_reg      <= '0;
                            quo_reg      <= bus.op ? bus.a : bus.b;
                            operand_reg  <= bus.op ? bus.b : bus.a;
                            bus.alu_sel  <= 1'b1;
                            bus.alu_op   <= bus.op ? ALU_SUB : ALU_ADD;
                            // First DIVU step shifts the dividend MSB into an empty remainder.
                            bus.alu_srca <= bus.op ? {{(WIDTH-1){1'b0}}, bus.a[WIDTH-1]} : '0;
                            bus.alu_srcb <= bus.op ? bus.b : bus.a;
                            state_reg    <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_reg <= acc_next;
                    quo_reg <= quo_next;
                    if (count_reg == '0) begin
                        bus.hi       <= acc_next;
                        bus.lo       <= quo_next;
                        bus.done     <= 1'b1;
                        bus.alu_sel  <= 1'b0;
                        bus.alu_srca <= '0;
                        bus.alu_srcb <= '0;
                        bus.alu_op   <= ALU_ADD;
                        state_reg    <= DONE;
                    end else begin
                        count_reg    <= count_reg - 1'b1;
                        bus.alu_srca <= srca_next;
                    end
                end
                DONE: begin
                    bus.done  <= 1'b0;
                    bus.busy  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: a cycle-level model built from plain arithmetic (a*b, a/b, a%b)
// and latency rules, compared on every negedge, plus literal result/latency expectations.
module tb_muldiv_sequencer;
    localparam int         W   = 32;
    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;

    logic clk = 1'b0;
    logic rst = 1'b0;

    muldiv_sequencer_if #(.WIDTH(W)) bus();

    muldiv_sequencer #(.WIDTH(W), .ALU_ADD(ADD), .ALU_SUB(SUB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Shared ALU stand-in.
    assign bus.alu_result = (bus.alu_op == SUB) ? (bus.alu_srca - bus.alu_srcb)
                                                : (bus.alu_srca + bus.alu_srcb);

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_left = cycles remaining in the operation, counting the done cycle.
    int         m_left = 0;
    logic       m_op   = 1'b0;
    logic [W-1:0] m_a  = '0;
    logic [W-1:0] m_b  = '0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_op   <= 1'b0;
        end else if (m_left == 0) begin
            if (bus.start) begin
                m_op <= bus.op;
                m_a  <= bus.a;
                m_b  <= bus.b;
                if (bus.op && bus.b == '0) begin
                    m_left <= 1;
                    m_hi   <= bus.a;
                    m_lo   <= '1;
                end else begin
                    m_left <= W + 1;
                end
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                if (m_op) begin
                    m_hi <= m_a % m_b;
                    m_lo <= m_a / m_b;
                end else begin
                    {m_hi, m_lo} <= 64'(m_a) * 64'(m_b);
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic in_run;
        in_run = (m_left > 1);
        check("busy",    64'(bus.busy),    64'(m_left > 0));
        check("done",    64'(bus.done),    64'(m_left == 1));
        check("alu_sel", 64'(bus.alu_sel), 64'(in_run));
        check("alu_op",  64'(bus.alu_op),  64'(in_run ? (m_op ? SUB : ADD) : ADD));
        check("alu_srcb", 64'(bus.alu_srcb), 64'(in_run ? (m_op ? m_b : m_a) : '0));
        if (!in_run) check("alu_srca_idle", 64'(bus.alu_srca), 64'd0);
        check("hi", 64'(bus.hi), 64'(m_hi));
        check("lo", 64'(bus.lo), 64'(m_lo));
    end

    // Issue one operation; optionally poke start during RUN (poke_at) or in the DONE cycle.
    task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input int elat,
                         input int poke_at, input bit poke_done);
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (lat == poke_at) begin
                bus.start = 1'b1; bus.op = ~o; bus.a = x ^ 32'h5A5A; bus.b = y + 3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check("latency", 64'(lat), 64'(elat));
        check("hi_result", 64'(bus.hi), 64'(eh));
        check("lo_result", 64'(bus.lo), 64'(el));
        $display("[TB] op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h latency=%0d",
                 o, x, y, bus.hi, bus.lo, lat);
        if (poke_done) begin
            bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'h77; bus.b = '0;
            @(negedge clk);
            bus.start = 1'b0;
            check("start_in_done_ignored", 64'(bus.busy), 64'd0);
            check("hi_held", 64'(bus.hi), 64'(eh));
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_busy",   64'(bus.busy),   64'd0);
        check("reset_hi",     64'(bus.hi),     64'd0);
        check("reset_lo",     64'(bus.lo),     64'd0);
        check("reset_alu_op", 64'(bus.alu_op), 64'(ADD));
        rst = 1'b0;

        do_op(1'b0, 32'd7,        32'd6,        32'h0,        32'h2A,       33, 0, 0);
        do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 0, 0);
        do_op(1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       33, 0, 0);
        do_op(1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 33, 0, 0);
        do_op(1'b1, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 1,  0, 0);
        // start during RUN is ignored; start in DONE is ignored; next call is back-to-back
        do_op(1'b0, 32'd7,        32'd6,        32'h0,        32'h2A,       33, 5, 1);
        do_op(1'b0, 32'h10000,    32'h10000,    32'h1,        32'h0,        33, 0, 0);
        do_op(1'b1, 32'd45,       32'd9,        32'd0,        32'd5,        33, 0, 0);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'h12345678; bus.b = 32'h9ABCDEF0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_before_rst", 64'(bus.busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_busy",    64'(bus.busy),    64'd0);
        check("rst_alu_sel", 64'(bus.alu_sel), 64'd0);
        check("rst_hi",      64'(bus.hi),      64'd0);
        check("rst_lo",      64'(bus.lo),      64'd0);
        check("rst_done",    64'(bus.done),    64'd0);
        $display("[TB] reset asserted mid-RUN");
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (40) @(negedge clk);
        do_op(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 33, 0, 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
